// File: rtl/decode_ctrl_unit.sv
// Front-end control for the single-cycle RV32I core: PC register, field/immediate decode,
// datapath control and next-PC resolution. Define DECODE_ILLEGAL_CHECK_EN to flag and squash illegal encodings.
module decode_ctrl_unit #(
    parameter int          DWIDTH   = 32,
    parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic [31:0]       instr,
    input  logic [DWIDTH-1:0] rs1_val,
    input  logic [DWIDTH-1:0] rs2_val,
    output logic [DWIDTH-1:0] pc,
    output logic [DWIDTH-1:0] pc_plus_4,
    output logic [DWIDTH-1:0] next_pc,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [DWIDTH-1:0] imm,
    output logic              reg_we,
    output logic [3:0]        alu_op,
    output logic [1:0]        op_a_sel,
    output logic              op_b_sel,
    output logic [1:0]        wb_sel,
    output logic              mem_re,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic              mem_unsigned,
    output logic              br_taken,
    output logic              illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic       B_RS2  = 1'b0;
    localparam logic       B_IMM  = 1'b1;
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] SZ_BYTE = 2'd0;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        reg_we_raw, mem_re_raw, mem_we_raw;

    // alt selects SUB for funct3=000 and SRA for funct3=101; callers decide when alt applies
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];
    assign shamt  = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (pc_en) begin
            pc <= next_pc;
        end
    end

    assign pc_plus_4 = pc + 32'd4;

    always_comb begin
        imm          = 32'd0;
        reg_we_raw   = 1'b0;
        mem_re_raw   = 1'b0;
        mem_we_raw   = 1'b0;
        alu_op       = ALU_ADD;
        op_a_sel     = A_RS1;
        op_b_sel     = B_RS2;
        wb_sel       = WB_ALU;
        mem_size     = SZ_BYTE;
        mem_unsigned = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm        = imm_u;
                reg_we_raw = 1'b1;
                op_a_sel   = A_ZERO;
                op_b_sel   = B_IMM;
            end
            OPC_AUIPC: begin
                imm        = imm_u;
                reg_we_raw = 1'b1;
                op_a_sel   = A_PC;
                op_b_sel   = B_IMM;
            end
            OPC_JAL: begin
                imm        = imm_j;
                reg_we_raw = 1'b1;
                op_a_sel   = A_PC;
                op_b_sel   = B_IMM;
                wb_sel     = WB_PC4;
            end
            OPC_JALR: begin
                imm        = imm_i;
                reg_we_raw = 1'b1;
                op_b_sel   = B_IMM;
                wb_sel     = WB_PC4;
            end
            OPC_BRANCH: begin
                imm    = imm_b;
                alu_op = ALU_SUB;
            end
            OPC_LOAD: begin
                imm          = imm_i;
                reg_we_raw   = 1'b1;
                mem_re_raw   = 1'b1;
                op_b_sel     = B_IMM;
                wb_sel       = WB_MEM;
                mem_size     = funct3[1:0];
                mem_unsigned = funct3[2];
            end
            OPC_STORE: begin
                imm        = imm_s;
                mem_we_raw = 1'b1;
                op_b_sel   = B_IMM;
                mem_size   = funct3[1:0];
            end
            OPC_OP_IMM: begin
                imm        = imm_i;
                reg_we_raw = 1'b1;
                op_b_sel   = B_IMM;
                // ADDI has no SUB form, so funct7[5] only matters for the shift
                alu_op     = alu_from_f3(funct3, funct7[5] && (funct3 == 3'b101));
            end
            OPC_OP: begin
                reg_we_raw = 1'b1;
                alu_op     = alu_from_f3(funct3, funct7[5]);
            end
            default: ;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
        if (opcode != OPC_BRANCH) begin
            br_taken = 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    always_comb begin
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM: illegal = 1'b0;
            OPC_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OPC_LOAD:   illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            OPC_STORE:  illegal = (funct3 >= 3'b011);
            OPC_OP:     illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            default:    illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        case (opcode)
            OPC_JAL:    next_pc = pc + imm_j;
            OPC_JALR:   next_pc = (rs1_val + imm_i) & ~32'h1;
            OPC_BRANCH: next_pc = br_taken ? (pc + imm_b) : pc_plus_4;
            default:    next_pc = pc_plus_4;
        endcase
        if (illegal) begin
            next_pc = pc_plus_4;
        end
    end

    // Side-effect strobes are squashed during reset, for illegal encodings and for rd=x0 writes
    assign reg_we = reg_we_raw && (rd != 5'd0) && reset && !illegal;
    assign mem_re = mem_re_raw && reset && !illegal;
    assign mem_we = mem_we_raw && reset && !illegal;

endmodule

// File: tb/tb_decode_ctrl_unit.sv
// Self-checking bench for decode_ctrl_unit: directed vector table, PC/reset sequences,
// and random instructions checked against an arithmetic reference model.
module tb_decode_ctrl_unit;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] imm;
        logic        reg_we;
        logic [3:0]  alu;
        logic [1:0]  a;
        logic        b;
        logic [1:0]  wb;
        logic        re;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic        br;
        logic [31:0] npc;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] r1;
        logic [31:0] r2;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, pc_en;
    logic [31:0] instr, rs1_val, rs2_val;
    logic [31:0] pc, pc_plus_4, next_pc, imm;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd, shamt;
    logic        reg_we, op_b_sel, mem_re, mem_we, mem_unsigned, br_taken, illegal;
    logic [3:0]  alu_op;
    logic [1:0]  op_a_sel, wb_sel, mem_size;

    int total = 0;
    int bad   = 0;

    decode_ctrl_unit #(.DWIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .instr(instr),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .pc_plus_4(pc_plus_4),
        .next_pc(next_pc), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .shamt(shamt), .imm(imm), .reg_we(reg_we),
        .alu_op(alu_op), .op_a_sel(op_a_sel), .op_b_sel(op_b_sel), .wb_sel(wb_sel),
        .mem_re(mem_re), .mem_we(mem_we), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .br_taken(br_taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] i, input logic w, input logic [3:0] alu,
                                input logic [1:0] a, input logic b, input logic [1:0] wb,
                                input logic re, input logic we, input logic [1:0] sz,
                                input logic un, input logic br, input logic [31:0] npc);
        exp_t e;
        e.imm = i; e.reg_we = w; e.alu = alu; e.a = a; e.b = b; e.wb = wb;
        e.re = re; e.we = we; e.size = sz; e.uns = un; e.br = br; e.npc = npc;
        return e;
    endfunction

    function automatic exp_t got_now();
        return {imm, reg_we, alu_op, op_a_sel, op_b_sel, wb_sel, mem_re, mem_we,
                mem_size, mem_unsigned, br_taken, next_pc};
    endfunction

    // Reference: immediates built from weighted bit positions, behaviour by mnemonic
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] x1, input logic [31:0] x2,
                                   output logic ill);
        exp_t        e;
        logic [31:0] ii, si, bi, ui, ji;
        logic [2:0]  f3;
        logic [3:0]  base [8];
        int signed   s1, s2;
        bit          legal, take;
        base  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        f3    = ins[14:12];
        s1    = x1;
        s2    = x2;
        legal = 1'b1;
        take  = 1'b0;
        e     = '0;
        ii = 32'($signed(ins) >>> 20);
        si = {ii[31:5], ins[11:7]};
        bi = (ins[31] ? 32'hFFFF_F000 : 32'h0) + (32'(ins[7]) << 11)
           + (32'(ins[30:25]) << 5) + (32'(ins[11:8]) << 1);
        ui = ins & 32'hFFFF_F000;
        ji = (ins[31] ? 32'hFFF0_0000 : 32'h0) + (32'(ins[19:12]) << 12)
           + (32'(ins[20]) << 11) + (32'(ins[30:21]) << 1);
        e.npc = p + 32'd4;
        case (ins[6:0])
            7'h37: begin e.imm = ui; e.reg_we = 1; e.a = 2; e.b = 1; end
            7'h17: begin e.imm = ui; e.reg_we = 1; e.a = 1; e.b = 1; end
            7'h6F: begin e.imm = ji; e.reg_we = 1; e.a = 1; e.b = 1; e.wb = 2; e.npc = p + ji; end
            7'h67: begin e.imm = ii; e.reg_we = 1; e.b = 1; e.wb = 2; e.npc = (x1 + ii) & ~32'h1; end
            7'h63: begin
                e.imm = bi; e.alu = 1;
                case (f3)
                    3'd0: take = (x1 == x2);
                    3'd1: take = (x1 != x2);
                    3'd4: take = (s1 < s2);
                    3'd5: take = (s1 >= s2);
                    3'd6: take = (x1 < x2);
                    3'd7: take = (x1 >= x2);
                    default: legal = 1'b0;
                endcase
                e.br = take;
                if (take) e.npc = p + bi;
            end
            7'h03: begin
                e.imm = ii; e.reg_we = 1; e.re = 1; e.wb = 1; e.b = 1;
                e.size = f3[1:0]; e.uns = f3[2];
                legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
            end
            7'h23: begin e.imm = si; e.we = 1; e.b = 1; e.size = f3[1:0]; legal = (f3 < 3); end
            7'h13: begin
                e.imm = ii; e.reg_we = 1; e.b = 1;
                e.alu = (f3 == 5 && ins[30]) ? 4'd7 : base[f3];
            end
            7'h33: begin
                e.reg_we = 1;
                e.alu = (ins[30] && f3 == 0) ? 4'd1 : (ins[30] && f3 == 5) ? 4'd7 : base[f3];
                legal = (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20);
            end
            default: legal = 1'b0;
        endcase
        if (ins[11:7] == 5'd0) e.reg_we = 0;
        if (ILL_EN && !legal) begin
            e.reg_we = 0; e.re = 0; e.we = 0; e.npc = p + 32'd4;
        end
        ill = ILL_EN && !legal;
        return e;
    endfunction

    vec_t        tbl [16];
    logic [6:0]  opcs [10];
    exp_t        e;
    logic        eill;
    logic [31:0] mpc, ins;

    initial begin
        // Directed vectors, all evaluated with pc held at 0x01000010
        tbl[0]  = '{32'h00500093, 32'h0, 32'h0, mk(32'd5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h01000014)};
        tbl[1]  = '{32'hFE208EE3, 32'd7, 32'd7, mk(32'hFFFFFFFC, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0100000C)};
        tbl[2]  = '{32'hFE208EE3, 32'd7, 32'd8, mk(32'hFFFFFFFC, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h01000014)};
        tbl[3]  = '{32'h004100E7, 32'h01000101, 32'h0, mk(32'd4, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 32'h01000104)};
        tbl[4]  = '{32'h00334283, 32'h0, 32'h0, mk(32'd3, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 32'h01000014)};
        tbl[5]  = '{32'h00112023, 32'h0, 32'h0, mk(32'd0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 32'h01000014)};
        tbl[6]  = '{32'h00000033, 32'h0, 32'h0, mk(32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h01000014)};
        tbl[7]  = '{32'h123451B7, 32'h0, 32'h0, mk(32'h12345000, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 32'h01000014)};
        tbl[8]  = '{32'hFFFFF217, 32'h0, 32'h0, mk(32'hFFFFF000, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h01000014)};
        tbl[9]  = '{32'hFF1FF0EF, 32'h0, 32'h0, mk(32'hFFFFFFF0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 32'h01000000)};
        tbl[10] = '{32'h407302B3, 32'h0, 32'h0, mk(32'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h01000014)};
        tbl[11] = '{32'h40335293, 32'h0, 32'h0, mk(32'h403, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 32'h01000014)};
        tbl[12] = '{32'h0020C463, 32'hFFFFFFFF, 32'd1, mk(32'd8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h01000018)};
        tbl[13] = '{32'h0020E463, 32'hFFFFFFFF, 32'd1, mk(32'd8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h01000014)};
        tbl[14] = '{32'h00000073, 32'h0, 32'h0, mk(32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h01000014)};
        tbl[15] = '{32'h00111023, 32'h0, 32'h0, mk(32'd0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 32'h01000014)};
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

        reset = 1'b0; pc_en = 1'b0; instr = 32'h13; rs1_val = 32'h0; rs2_val = 32'h0;

        // Reset phase: strobes squashed, PC loaded
        @(negedge clk);
        instr = 32'h00002083;
        #1;
        chk("rst_reg_we", 128'(reg_we), 128'(0));
        chk("rst_mem_re", 128'(mem_re), 128'(0));
        chk("rst_pc", 128'(pc), 128'(RESET_PC));
        @(negedge clk);
        instr = 32'h00000013; pc_en = 1'b1; reset = 1'b1;
        #1;
        chk("rel_pc0", 128'(pc), 128'(32'h01000000));
        @(negedge clk);
        chk("rel_pc1", 128'(pc), 128'(32'h01000004));
        repeat (3) @(negedge clk);
        chk("pc_at_10", 128'(pc), 128'(32'h01000010));

        pc_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            instr = tbl[i].instr; rs1_val = tbl[i].r1; rs2_val = tbl[i].r2;
            #1;
            chk($sformatf("vec%0d", i), 128'(got_now()), 128'(tbl[i].e));
            @(negedge clk);
        end
        chk("hold_tbl", 128'(pc), 128'(32'h01000010));

        instr = 32'hFF1FF0EF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d", i), 128'(pc), 128'(32'h01000010));
        end

        mpc = 32'h01000010;
        for (int i = 0; i < 400; i++) begin
            ins = {$urandom()} & 32'hFFFF_FF80;
            ins[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom()) : opcs[$urandom_range(0, 9)];
            if (ins[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
                ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            instr   = ins;
            rs1_val = $urandom();
            case ($urandom_range(0, 3))
                0:       rs2_val = rs1_val;
                1:       rs2_val = 32'($urandom_range(0, 3)) - 32'd1;
                default: rs2_val = $urandom();
            endcase
            pc_en = ($urandom_range(0, 3) != 0);
            #1;
            e = model(ins, mpc, rs1_val, rs2_val, eill);
            chk($sformatf("rnd%0d_pc", i), 128'(pc), 128'(mpc));
            chk($sformatf("rnd%0d_pc4", i), 128'(pc_plus_4), 128'(mpc + 32'd4));
            chk($sformatf("rnd%0d_ctl ins=%h", i, ins), 128'(got_now()), 128'(e));
            chk($sformatf("rnd%0d_ill", i), 128'(illegal), 128'(eill));
            chk($sformatf("rnd%0d_fld", i), 128'({opcode, funct3, funct7, rs1, rs2, rd, shamt}),
                128'({ins[6:0], ins[14:12], ins[31:25], ins[19:15], ins[24:20], ins[11:7], ins[24:20]}));
            if (pc_en) mpc = e.npc;
            @(negedge clk);
        end

        // Reset asserted mid-run: strobes drop immediately, PC reloads at the edge
        reset = 1'b0; instr = 32'h00002083;
        #1;
        chk("mid_rst_reg_we", 128'(reg_we), 128'(0));
        chk("mid_rst_mem_re", 128'(mem_re), 128'(0));
        instr = 32'h00112023;
        #1;
        chk("mid_rst_mem_we", 128'(mem_we), 128'(0));
        @(negedge clk);
        chk("mid_rst_pc", 128'(pc), 128'(RESET_PC));
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
